temp_alarm_controller: RTL and testbench
========================================

// Module: temp_alarm_controller
// PURPOSE
//   Sequential consumer of lowTempAbnormality / highTempAbnormality from the temperature
//   abnormality detector. Filters glitches (N-sample confirmation), drives heater/cooler
//   actuators, escalates unresolved or contradictory conditions to a latched fault that
//   is cleared only by operator acknowledge. Sits between the detector and the panel/actuators.
// PARAMETERS
//   CONFIRM_CYCLES  4   consecutive identical samples needed to confirm an abnormality (>=1)
//   RECOVER_CYCLES  2   consecutive clear samples needed to end heating/cooling (>=1)
//   MAX_ACTIVE      16  cycles allowed in HEATING/COOLING before escalating to FAULT (>=2)
//   CNT_W           5   width of internal counters; must hold MAX_ACTIVE-1
// PORTS
//   clk                  in   1  system clock, rising edge
//   rst_n                in   1  asynchronous active-low reset
//   lowTempAbnormality   in   1  from detector: temperature below allowed band
//   highTempAbnormality  in   1  from detector: temperature above allowed band
//   alarmAck             in   1  operator acknowledge; only meaningful in FAULT
//   heaterOn             out  1  heater enable
//   coolerOn             out  1  cooler enable
//   alarmOut             out  1  panel alarm lamp
//   faultOut             out  1  latched fault indicator
//   state                out  3  FSM state code (debug / panel)
// BEHAVIOUR
// - Single clock domain; inputs sampled every rising edge; all outputs registered (Moore,
//   decoded from state register). rst_n low -> immediately: state=IDLE, all counters 0,
//   heaterOn=coolerOn=alarmOut=faultOut=0. Reset mid-operation (any state) behaves identically.
// - States: IDLE=0, CONF_LOW=1, CONF_HIGH=2, HEATING=3, COOLING=4, FAULT=5; 6,7 unused -> IDLE.
// - Outputs: HEATING: heaterOn=1,alarmOut=1. COOLING: coolerOn=1,alarmOut=1.
//   FAULT: faultOut=1,alarmOut=1, heater/cooler 0. All other states: all 0.
// - Global priority (every state except FAULT): low=1 AND high=1 in same sample -> FAULT next.
// - IDLE: low -> CONF_LOW, cnt=1; high -> CONF_HIGH, cnt=1; neither -> stay.
//   If CONFIRM_CYCLES==1: low -> HEATING, high -> COOLING directly.
// - CONF_LOW: low=1: if cnt==CONFIRM_CYCLES-1 -> HEATING else cnt++.
//   high=1 -> CONF_HIGH, cnt=1. neither -> IDLE, cnt=0. CONF_HIGH symmetric (-> COOLING).
//   => actuator rises on the edge of the CONFIRM_CYCLES-th consecutive asserted sample.
// - HEATING (entry: actCnt=0, recCnt=0), each cycle:
//   1) high=1 (overshoot) -> CONF_HIGH, cnt=1 (heater off next cycle).
//   2) low=0: recCnt++; if recCnt==RECOVER_CYCLES-1 -> IDLE. low=1: recCnt=0.
//   3) actCnt==MAX_ACTIVE-1 and not leaving via 1)/2) -> FAULT; else actCnt++.
//   Recovery takes priority over timeout in the same cycle. COOLING symmetric (low<->high).
// - FAULT: latched. Exit to IDLE only when alarmAck=1 AND low=0 AND high=0 in same sample;
//   ack with any abnormality still asserted is ignored (stay FAULT). alarmAck ignored elsewhere.
// - Counters saturate, never wrap; heaterOn and coolerOn are never both 1 (by construction).
// TESTING (defaults CONFIRM=4, RECOVER=2, MAX_ACTIVE=16)
// 1 Reset: rst_n=0 mid-HEATING, between clock edges -> all outputs 0, state=0 immediately.
// 2 Confirm: low=1 for 4 edges -> heaterOn=1 after 4th edge, state=3; low=1 for 3 edges
//   then 0 -> stays 0, state returns to 0; glitch 1-0-1 restarts count.
// 3 Recovery: in HEATING drop low for 2 edges -> state=0, heaterOn=0; 1 clear edge then
//   low=1 again -> stays HEATING, recCnt reset.
// 4 Timeout: hold high=1 -> COOLING after 4 edges, FAULT 16 edges later: coolerOn=0,
//   faultOut=1; alarmAck=1 with high=1 -> stays 5; ack with inputs 0 -> state=0 next edge.
// 5 Contradiction: low=high=1 one sample from IDLE and from CONF_LOW -> state=5 next edge.
// 6 Overshoot: in HEATING assert high only -> state=2, heaterOn=0 next edge, COOLING 3 later.

Source files
------------

// File: rtl/temp_alarm_controller.sv
// Temperature alarm controller: confirms detector abnormalities over several samples,
// drives the heater or cooler, and latches a fault until the operator acknowledges it.
module temp_alarm_controller #(
  parameter int CONFIRM_CYCLES = 4,
  parameter int RECOVER_CYCLES = 2,
  parameter int MAX_ACTIVE     = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lowTempAbnormality,
  input  logic       highTempAbnormality,
  input  logic       alarmAck,
  output logic       heaterOn,
  output logic       coolerOn,
  output logic       alarmOut,
  output logic       faultOut,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONF_LOW  = 3'd1,
    CONF_HIGH = 3'd2,
    HEATING   = 3'd3,
    COOLING   = 3'd4,
    FAULT     = 3'd5
  } stateT;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(MAX_ACTIVE - 1);

  stateT            stateReg, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] actCnt, actCntNext;
  logic [CNT_W-1:0] recCnt, recCntNext;
  logic             bothAbn;
  logic             ownAbn, otherAbn;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign bothAbn = lowTempAbnormality & highTempAbnormality;
  assign state   = stateReg;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    stateNext  = stateReg;
    cntNext    = cnt;
    actCntNext = actCnt;
    recCntNext = recCnt;
    ownAbn     = 1'b0;
    otherAbn   = 1'b0;

    case (stateReg)
      IDLE: begin
        cntNext = '0;
        if (bothAbn) begin
          stateNext = FAULT;
        end else if (lowTempAbnormality) begin
          if (CONFIRM_CYCLES == 1) begin
            stateNext  = HEATING;
            actCntNext = '0;
            recCntNext = '0;
          end else begin
            stateNext = CONF_LOW;
            cntNext   = CNT_ONE;
          end
        end else if (highTempAbnormality) begin
          if (CONFIRM_CYCLES == 1) begin
            stateNext  = COOLING;
            actCntNext = '0;
            recCntNext = '0;
          end else begin
            stateNext = CONF_HIGH;
            cntNext   = CNT_ONE;
          end
        end
      end

      CONF_LOW, CONF_HIGH: begin
        ownAbn   = (stateReg == CONF_LOW) ? lowTempAbnormality : highTempAbnormality;
        otherAbn = (stateReg == CONF_LOW) ? highTempAbnormality : lowTempAbnormality;
        if (bothAbn) begin
          stateNext = FAULT;
          cntNext   = '0;
        end else if (ownAbn) begin
          // >= keeps a re-entry via overshoot safe when CONFIRM_CYCLES is 1.
          if (cnt >= CONF_LAST) begin
            if (stateReg == CONF_LOW) stateNext = HEATING;
            else                      stateNext = COOLING;
            cntNext    = '0;
            actCntNext = '0;
            recCntNext = '0;
          end else begin
            cntNext = satInc(cnt);
          end
        end else if (otherAbn) begin
          if (stateReg == CONF_LOW) stateNext = CONF_HIGH;
          else                      stateNext = CONF_LOW;
          cntNext = CNT_ONE;
        end else begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      end

      HEATING, COOLING: begin
        ownAbn   = (stateReg == HEATING) ? lowTempAbnormality : highTempAbnormality;
        otherAbn = (stateReg == HEATING) ? highTempAbnormality : lowTempAbnormality;
        if (bothAbn) begin
          stateNext = FAULT;
        end else if (otherAbn) begin
          // Overshoot: start confirming the opposite condition from one sample.
          if (stateReg == HEATING) stateNext = CONF_HIGH;
          else                     stateNext = CONF_LOW;
          cntNext = CNT_ONE;
        end else begin
          recCntNext = ownAbn ? '0 : satInc(recCnt);
          if (!ownAbn && (recCnt >= REC_LAST)) begin
            stateNext  = IDLE;
            cntNext    = '0;
            actCntNext = '0;
            recCntNext = '0;
          end else if (actCnt >= ACT_LAST) begin
            stateNext = FAULT;
          end else begin
            actCntNext = satInc(actCnt);
          end
        end
      end

      FAULT: begin
        cntNext    = '0;
        actCntNext = '0;
        recCntNext = '0;
        if (alarmAck && !lowTempAbnormality && !highTempAbnormality) stateNext = IDLE;
      end

      default: begin
        stateNext  = IDLE;
        cntNext    = '0;
        actCntNext = '0;
        recCntNext = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change together with stateReg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      cnt      <= '0;
      actCnt   <= '0;
      recCnt   <= '0;
      heaterOn <= 1'b0;
      coolerOn <= 1'b0;
      alarmOut <= 1'b0;
      faultOut <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      stateReg <= stateNext;
      cnt      <= cntNext;
      actCnt   <= actCntNext;
      recCnt   <= recCntNext;
      heaterOn <= (stateNext == HEATING);
      coolerOn <= (stateNext == COOLING);
      alarmOut <= (stateNext == HEATING) || (stateNext == COOLING) || (stateNext == FAULT);
      faultOut <= (stateNext == FAULT);
    end
  end

endmodule

// File: tb/tb_temp_alarm_controller.sv
// Self-checking bench for temp_alarm_controller: directed vector table, hand-written
// corner sequences, then random stimulus against a run-length reference model.
module tb_temp_alarm_controller;

  localparam int CONFIRM = 4;
  localparam int RECOVER = 2;
  localparam int MAXACT  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lowTempAbnormality, highTempAbnormality, alarmAck;
  logic       heaterOn, coolerOn, alarmOut, faultOut;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  temp_alarm_controller #(
    .CONFIRM_CYCLES(CONFIRM),
    .RECOVER_CYCLES(RECOVER),
    .MAX_ACTIVE(MAXACT),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lowTempAbnormality(lowTempAbnormality),
    .highTempAbnormality(highTempAbnormality),
    .alarmAck(alarmAck),
    .heaterOn(heaterOn),
    .coolerOn(coolerOn),
    .alarmOut(alarmOut),
    .faultOut(faultOut),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit         lo;
    bit         hi;
    bit         ack;
    logic [2:0] st;
  } vecT;

  vecT vecs[$];

  // Output pattern {heater, cooler, alarm, fault} that each state code must show.
  function automatic logic [3:0] expOut(input logic [2:0] st);
    case (st)
      3'd3:    return 4'b1010;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [2:0] expSt);
    logic [6:0] act, exp;
    act = {state, heaterOn, coolerOn, alarmOut, faultOut};
    exp = {expSt, expOut(expSt)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d hcaf=%b, expected state=%0d hcaf=%b",
               name, act[6:4], act[3:0], exp[6:4], exp[3:0]);
    end
  endtask

  task automatic tick(input bit lo, input bit hi, input bit ack);
    @(negedge clk);
    lowTempAbnormality  = lo;
    highTempAbnormality = hi;
    alarmAck            = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic tickCheck(input string name, input bit lo, input bit hi, input bit ack,
                           input logic [2:0] expSt);
    tick(lo, hi, ack);
    check(name, expSt);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    lowTempAbnormality  = 1'b0;
    highTempAbnormality = 1'b0;
    alarmAck            = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: counts run lengths of samples rather than tracking counter registers.
  int mMode, mStreak, mAge, mClear;

  task automatic modelReset();
    mMode = 0; mStreak = 0; mAge = 0; mClear = 0;
  endtask

  task automatic modelStep(input bit lo, input bit hi, input bit ack);
    bit own, other, isHigh;
    int pending;
    if (mMode != 5 && lo && hi) begin
      mMode = 5;
    end else if (mMode == 5) begin
      if (ack && !lo && !hi) begin mMode = 0; mStreak = 0; end
    end else if (mMode == 3 || mMode == 4) begin
      own   = (mMode == 3) ? lo : hi;
      other = (mMode == 3) ? hi : lo;
      if (other) begin
        mMode   = (mMode == 3) ? 2 : 1;
        mStreak = 1;
      end else begin
        mAge   = mAge + 1;
        mClear = own ? 0 : mClear + 1;
        if (mClear >= RECOVER) begin mMode = 0; mStreak = 0; end
        else if (mAge >= MAXACT) mMode = 5;
      end
    end else if (!lo && !hi) begin
      mMode = 0; mStreak = 0;
    end else begin
      isHigh  = hi;
      pending = isHigh ? 2 : 1;
      mStreak = (mMode == pending) ? mStreak + 1 : 1;
      if (mStreak >= CONFIRM) begin
        mMode = isHigh ? 4 : 3; mAge = 0; mClear = 0;
      end else begin
        mMode = pending;
      end
    end
  endtask

  initial begin
    bit lo, hi, ack;
    int kind, len;

    rst_n = 1'b0;
    lowTempAbnormality  = 1'b0;
    highTempAbnormality = 1'b0;
    alarmAck            = 1'b0;
    #12;
    check("reset_state", 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, applied back to back from IDLE.
    vecs.push_back('{1, 0, 0, 3'd1});  // confirm fails after three samples
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{0, 0, 0, 3'd0});
    vecs.push_back('{1, 0, 0, 3'd1});  // glitch 1-0-1 restarts count
    vecs.push_back('{0, 0, 0, 3'd0});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd3});  // fourth sample -> HEATING
    vecs.push_back('{0, 0, 0, 3'd3});  // one clear sample, then low again
    vecs.push_back('{1, 0, 0, 3'd3});
    vecs.push_back('{0, 0, 0, 3'd3});
    vecs.push_back('{0, 0, 0, 3'd0});  // two clear samples -> IDLE
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd3});
    vecs.push_back('{0, 1, 0, 3'd2});  // overshoot -> CONF_HIGH
    vecs.push_back('{0, 1, 0, 3'd2});
    vecs.push_back('{0, 1, 0, 3'd2});
    vecs.push_back('{0, 1, 0, 3'd4});  // COOLING three edges later
    vecs.push_back('{0, 0, 0, 3'd4});
    vecs.push_back('{0, 0, 0, 3'd0});
    vecs.push_back('{1, 1, 0, 3'd5});  // contradiction from IDLE
    vecs.push_back('{0, 0, 1, 3'd0});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 1, 0, 3'd5});  // contradiction from CONF_LOW
    vecs.push_back('{1, 0, 1, 3'd5});  // ack with abnormality ignored
    vecs.push_back('{0, 1, 1, 3'd5});
    vecs.push_back('{0, 0, 0, 3'd5});  // no ack, stays latched
    vecs.push_back('{0, 0, 1, 3'd0});
    vecs.push_back('{0, 0, 1, 3'd0});  // ack ignored in IDLE
    vecs.push_back('{0, 1, 0, 3'd2});
    vecs.push_back('{1, 0, 0, 3'd1});  // direction switch restarts at one
    vecs.push_back('{0, 0, 0, 3'd0});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd1});
    vecs.push_back('{1, 0, 0, 3'd3});
    vecs.push_back('{1, 1, 0, 3'd5});  // contradiction from HEATING
    vecs.push_back('{0, 0, 1, 3'd0});

    foreach (vecs[i])
      tickCheck($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].ack, vecs[i].st);

    // Async reset mid-HEATING, between clock edges.
    for (int i = 0; i < 3; i++) tick(1, 0, 0);
    tickCheck("reset_pre_heating", 1, 0, 0, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_mid_heating", 3'd0);
    @(negedge clk);
    lowTempAbnormality = 1'b0;
    rst_n = 1'b1;

    // Timeout from COOLING after MAX_ACTIVE cycles.
    for (int i = 0; i < 3; i++) tickCheck($sformatf("to_conf%0d", i), 0, 1, 0, 3'd2);
    tickCheck("to_enter_cooling", 0, 1, 0, 3'd4);
    for (int i = 1; i < MAXACT; i++) tickCheck($sformatf("to_cool%0d", i), 0, 1, 0, 3'd4);
    tickCheck("to_fault", 0, 1, 0, 3'd5);
    tickCheck("to_ack_with_high", 0, 1, 1, 3'd5);
    tickCheck("to_ack_clear", 0, 0, 1, 3'd0);

    // Recovery completes on the same edge the timeout would fire.
    for (int i = 0; i < 3; i++) tick(1, 0, 0);
    tickCheck("tie_heating", 1, 0, 0, 3'd3);
    for (int i = 0; i < MAXACT - 2; i++) tick(1, 0, 0);
    tickCheck("tie_clear1", 0, 0, 0, 3'd3);
    tickCheck("tie_recover_wins", 0, 0, 0, 3'd0);

    // Random segments against the reference model.
    doReset();
    modelReset();
    for (int seg = 0; seg < 80; seg++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, 22);
      for (int i = 0; i < len; i++) begin
        lo  = 1'b0;
        hi  = 1'b0;
        ack = ($urandom_range(0, 3) == 0);
        case (kind)
          0: lo = 1'b1;
          1: hi = 1'b1;
          2: ;
          3: begin
            lo = $urandom_range(0, 1);
            hi = !lo && ($urandom_range(0, 1) == 1);
          end
          4: begin
            lo  = ($urandom_range(0, 9) == 0);
            hi  = ($urandom_range(0, 9) == 0);
            ack = 1'b1;
          end
          default: begin
            lo = ($urandom_range(0, 5) != 0);
            hi = ($urandom_range(0, 19) == 0);
          end
        endcase
        tick(lo, hi, ack);
        modelStep(lo, hi, ack);
        check($sformatf("rand_s%0d_c%0d", seg, i), 3'(mMode));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
